// File: rtl/tiny_boot_loader.sv
// Serial program loader: receives a sync/length/data/checksum frame over rx into a 256x8 RAM, then releases the core.
// Latency: core_run rises one cycle after the checksum byte's stop-bit sample; core_rdata is combinational from RAM.
// Backpressure: none; rx is free-running 8N1. Optional TINY_LOADER_RELOAD_EN lets a 0xA5 byte in RUN restart loading.
module tiny_boot_loader #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rx,
    output logic       core_run,
    input  logic [7:0] core_addr,
    input  logic       core_write,
    input  logic [7:0] core_wdata,
    output logic [7:0] core_rdata,
    output logic       busy,
    output logic       load_error
);

    localparam logic [7:0] CNT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = 8'((CLKS_PER_BIT / 2) - 1);
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {HUNT, LEN, DATA, CSUM, RUN} state_t;

    logic [7:0] ram [256];

    // receiver
    logic       rx_meta, rx_sync, rx_prev;
    rx_state_t  rx_state, rx_state_nxt;
    logic [7:0] rx_cnt, rx_cnt_nxt;
    logic [2:0] rx_bit, rx_bit_nxt;
    logic [7:0] rx_shift, rx_shift_nxt;
    logic       byte_vld, byte_vld_nxt;
    logic       frame_err, frame_err_nxt;
    logic       rx_en;

    // frame FSM
    state_t     state, state_nxt;
    logic [8:0] len_rem, len_rem_nxt;
    logic [7:0] ptr, ptr_nxt;
    logic [7:0] sum, sum_nxt;
    logic       load_error_nxt;
    logic       ld_we;

    logic       ram_we;
    logic [7:0] ram_waddr;
    logic [7:0] ram_wdat;

`ifdef TINY_LOADER_RELOAD_EN
    assign rx_en = 1'b1;
`else
    assign rx_en = (state != RUN);
`endif

    // Sync flops reset low so a line already low at release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (nreset) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_state  <= rx_state_nxt;
            rx_cnt    <= rx_cnt_nxt;
            rx_bit    <= rx_bit_nxt;
            rx_shift  <= rx_shift_nxt;
            byte_vld  <= byte_vld_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        rx_state_nxt  = rx_state;
        rx_cnt_nxt    = rx_cnt + 8'd1;
        rx_bit_nxt    = rx_bit;
        rx_shift_nxt  = rx_shift;
        byte_vld_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_nxt = '0;
                rx_bit_nxt = '0;
                if (rx_prev && !rx_sync)
                    rx_state_nxt = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_nxt   = '0;
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_bit_nxt   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7)
                        rx_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt == CNT_LAST) begin
                    rx_cnt_nxt    = '0;
                    rx_state_nxt  = RX_IDLE;
                    byte_vld_nxt  = rx_sync;
                    frame_err_nxt = !rx_sync;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
        if (!rx_en) begin
            rx_state_nxt = RX_IDLE;
            rx_cnt_nxt   = '0;
            rx_bit_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            state      <= HUNT;
            len_rem    <= '0;
            ptr        <= '0;
            sum        <= '0;
            load_error <= 1'b0;
        end else begin
            state      <= state_nxt;
            len_rem    <= len_rem_nxt;
            ptr        <= ptr_nxt;
            sum        <= sum_nxt;
            load_error <= load_error_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        len_rem_nxt    = len_rem;
        ptr_nxt        = ptr;
        sum_nxt        = sum;
        load_error_nxt = load_error;
        ld_we          = 1'b0;
        if (frame_err) begin
            state_nxt      = HUNT;
            load_error_nxt = 1'b1;
        end else if (byte_vld) begin
            case (state)
                HUNT: begin
                    if (rx_shift == SYNC_BYTE)
                        state_nxt = LEN;
                end
                LEN: begin
                    len_rem_nxt = (rx_shift == 8'd0) ? 9'd256 : {1'b0, rx_shift};
                    ptr_nxt     = '0;
                    sum_nxt     = '0;
                    state_nxt   = DATA;
                end
                DATA: begin
                    ld_we       = 1'b1;
                    ptr_nxt     = ptr + 8'd1;
                    sum_nxt     = sum + rx_shift;
                    len_rem_nxt = len_rem - 9'd1;
                    if (len_rem == 9'd1)
                        state_nxt = CSUM;
                end
                CSUM: begin
                    if (rx_shift == sum) begin
                        state_nxt      = RUN;
                        load_error_nxt = 1'b0;
                    end else begin
                        state_nxt      = HUNT;
                        load_error_nxt = 1'b1;
                    end
                end
                RUN: begin
`ifdef TINY_LOADER_RELOAD_EN
                    if (rx_shift == SYNC_BYTE)
                        state_nxt = LEN;
`endif
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    // Loader and core writes are mutually exclusive by state; the loader path wins regardless.
    assign ram_we    = !nreset && (ld_we || (state == RUN && core_write));
    assign ram_waddr = ld_we ? ptr : core_addr;
    assign ram_wdat  = ld_we ? rx_shift : core_wdata;

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdat;
    end

    assign core_rdata = ram[core_addr];
    assign core_run   = (state == RUN);
    assign busy       = (state == LEN) || (state == DATA) || (state == CSUM);

endmodule

// File: tb/tb_tiny_boot_loader.sv
// Directed bench for tiny_boot_loader: drives 8N1 frames on rx and checks run/busy/error flags and RAM contents.
module tb_tiny_boot_loader;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       nreset;
    logic       rx;
    logic       core_run;
    logic [7:0] core_addr;
    logic       core_write;
    logic [7:0] core_wdata;
    logic [7:0] core_rdata;
    logic       busy;
    logic       load_error;

    int n_checks = 0;
    int n_errors = 0;

    tiny_boot_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .rx         (rx),
        .core_run   (core_run),
        .core_addr  (core_addr),
        .core_write (core_write),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .busy       (busy),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 byte plus two idle bit times; stop_ok=0 forces a framing error.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop_ok;
        wait_cyc(CPB);
        rx = 1'b1;
        wait_cyc(2 * CPB);
    endtask

    task automatic ram_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        core_addr = addr;
        #1;
        chk(tag, {24'd0, core_rdata}, {24'd0, exp});
    endtask

    task automatic core_wr(input logic [7:0] addr, input logic [7:0] dat);
        core_addr  = addr;
        core_wdata = dat;
        core_write = 1'b1;
        wait_cyc(1);
        core_write = 1'b0;
    endtask

    task automatic do_reset;
        nreset = 1'b1;
        wait_cyc(3);
        nreset = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        rx         = 1'b1;
        core_addr  = 8'd0;
        core_write = 1'b0;
        core_wdata = 8'd0;
        nreset     = 1'b1;
        @(negedge clk);
        wait_cyc(3);
        chk("rst_run",  {31'd0, core_run},   32'd0);
        chk("rst_busy", {31'd0, busy},       32'd0);
        chk("rst_err",  {31'd0, load_error}, 32'd0);
        nreset = 1'b0;
        wait_cyc(4);

        // Good frame: A5 03 11 22 33 66
        send_byte(8'hA5);
        chk("len_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        chk("data_busy", {31'd0, busy}, 32'd1);
        chk("data_run",  {31'd0, core_run}, 32'd0);
        send_byte(8'h33);
        send_byte(8'h66);
        chk("good_run",  {31'd0, core_run},   32'd1);
        chk("good_err",  {31'd0, load_error}, 32'd0);
        chk("good_busy", {31'd0, busy},       32'd0);
        ram_chk("good_ram0", 8'h00, 8'h11);
        ram_chk("good_ram1", 8'h01, 8'h22);
        ram_chk("good_ram2", 8'h02, 8'h33);

        // Core store in RUN
        core_wr(8'h80, 8'h5A);
        ram_chk("run_wr", 8'h80, 8'h5A);

        // Sync byte while running
        send_byte(8'hA5);
`ifdef TINY_LOADER_RELOAD_EN
        chk("reload_drop", {31'd0, core_run}, 32'd0);
`else
        chk("reload_keep", {31'd0, core_run}, 32'd1);
`endif
        send_byte(8'h01);
        send_byte(8'h07);
        send_byte(8'h07);
        chk("reload_run", {31'd0, core_run}, 32'd1);
`ifdef TINY_LOADER_RELOAD_EN
        ram_chk("reload_ram0", 8'h00, 8'h07);
`else
        ram_chk("reload_ram0", 8'h00, 8'h11);
`endif

        // Bad checksum, then a good frame
        do_reset();
        chk("rst2_run", {31'd0, core_run}, 32'd0);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h31);
        chk("bad_err",  {31'd0, load_error}, 32'd1);
        chk("bad_run",  {31'd0, core_run},   32'd0);
        chk("bad_busy", {31'd0, busy},       32'd0);
        ram_chk("bad_ram0", 8'h00, 8'h10);
        ram_chk("bad_ram1", 8'h01, 8'h20);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        chk("fix_err", {31'd0, load_error}, 32'd0);
        chk("fix_run", {31'd0, core_run},   32'd1);

        // Framing error on the length byte
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h03, 1'b0);
        chk("frm_err",  {31'd0, load_error}, 32'd1);
        chk("frm_busy", {31'd0, busy},       32'd0);
        send_byte(8'h42);
        chk("frm_42_busy", {31'd0, busy},       32'd0);
        chk("frm_42_err",  {31'd0, load_error}, 32'd1);
        chk("frm_42_run",  {31'd0, core_run},   32'd0);

        // Core store outside RUN has no effect
        core_wr(8'h80, 8'hC3);
        ram_chk("hunt_wr", 8'h80, 8'h5A);

        // Reset in the middle of a frame
        do_reset();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h44);
        send_byte(8'h55);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        do_reset();
        chk("mid_rst_busy", {31'd0, busy},     32'd0);
        chk("mid_rst_run",  {31'd0, core_run}, 32'd0);
        send_byte(8'h66);
        send_byte(8'hFF);
        chk("mid_tail_busy", {31'd0, busy},     32'd0);
        chk("mid_tail_run",  {31'd0, core_run}, 32'd0);
        ram_chk("mid_ram2", 8'h02, 8'h33);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h99);
        send_byte(8'h99);
        chk("mid_next_run", {31'd0, core_run}, 32'd1);
        ram_chk("mid_next_ram0", 8'h00, 8'h99);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tiny_boot_loader.md
TINY_BOOT_LOADER -- requirements
Module: tiny_boot_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (range 4..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port nreset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx  input  1  serial program input, 8N1, LSB first, idle high.
REQ-005 SHALL have port core_run  output  1  drives the core's run/reset input; 0 holds the core in reset, 1 lets it execute.
REQ-006 SHALL have port core_addr  input  8  core memory address.
REQ-007 SHALL have port core_write  input  1  core store strobe.
REQ-008 SHALL have port core_wdata  input  8  core store data.
REQ-009 SHALL have port core_rdata  output  8  memory read data for the core.
REQ-010 SHALL have port busy  output  1  loader is receiving a frame.
REQ-011 SHALL have port load_error  output  1  sticky flag: last frame failed checksum or framing.

Function
REQ-012 SHALL contain a 256x8 RAM; core_rdata = RAM[core_addr], combinational, in every state.
REQ-013 SHALL write RAM[core_addr] <= core_wdata on posedge only when core_write=1 and state=RUN.
REQ-014 SHALL receive bytes by detecting a rx 1->0 edge, re-checking rx=0 at CLKS_PER_BIT/2 (else abandon), sampling 8 data bits at bit centres, then checking the stop bit.
REQ-015 SHALL discard a byte whose stop bit is 0, set load_error, and return to HUNT.
REQ-016 SHALL use frame format: sync 0xA5, length N (0 means 256), N data bytes, checksum = 8-bit wrapping sum of the data bytes.
REQ-017 SHALL implement states HUNT, LEN, DATA, CSUM, RUN.
REQ-018 HUNT: ignore any byte except 0xA5; on 0xA5 go to LEN.
REQ-019 LEN: latch N, clear the write pointer and running sum, go to DATA.
REQ-020 DATA: write each byte to RAM[ptr] the cycle after its stop bit, ptr+1 with 8-bit wrap, sum+byte mod 256; after the N-th byte go to CSUM.
REQ-021 CSUM: on match, clear load_error and go to RUN; on mismatch, set load_error and go to HUNT; RAM contents written so far are retained.
REQ-022 SHALL drive core_run=1 only in RUN; core_run SHALL rise one cycle after the checksum byte's stop-bit sample.
REQ-023 SHALL drive busy=1 in LEN, DATA and CSUM, else 0.
REQ-024 SHALL give a core_write arriving in the same cycle as a loader write no effect; core_write is ignored outside RUN.

Reset
REQ-025 While nreset=1, state SHALL be HUNT, core_run=0, busy=0, load_error=0, and the receiver idle with counters zero; RAM contents are not cleared.
REQ-026 Reset asserted mid-byte or mid-frame SHALL abandon the byte or frame; after release, reception SHALL restart only on a fresh start edge.

Configuration
REQ-027 With TINY_LOADER_RELOAD_EN defined, a 0xA5 byte received in RUN SHALL drop core_run to 0 the next cycle and enter LEN.
REQ-028 Without TINY_LOADER_RELOAD_EN, RUN SHALL be terminal until reset and the receiver SHALL ignore rx in RUN.

Verification
REQ-029 Frame A5 03 11 22 33 66 -> RAM[0..2]=11,22,33; core_run=1; load_error=0; busy=0.
REQ-030 Frame A5 02 10 20 31 (bad checksum) -> load_error=1, core_run=0, state HUNT; a following good frame -> load_error=0, core_run=1.
REQ-031 Stop bit forced 0 on the length byte -> load_error=1, byte discarded, HUNT; a subsequent 0x42 is ignored.
REQ-032 In RUN, core_write=1, addr 0x80, wdata 0x5A -> core_rdata=0x5A at addr 0x80 next cycle; the same write in HUNT -> RAM unchanged.
REQ-033 With TINY_LOADER_RELOAD_EN: in RUN send A5 01 07 07 -> core_run 1->0->1, RAM[0]=07; without the macro -> core_run stays 1 and RAM[0] is unchanged.
REQ-034 nreset pulsed after the 2nd data byte of a 3-byte frame -> core_run=0, busy=0, HUNT; the remaining bytes are ignored until the next 0xA5.
